// File: rtl/sub_pkg.sv
// Shared constants, FSM state type and nibble select/insert helpers for the
// serial 16-bit subtractor.
package sub_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned NIBBLE      = 4;
    localparam int unsigned NUM_NIBBLES = 4;
    localparam int unsigned CNT_W       = 2;

    localparam logic [CNT_W-1:0] FIRST_NIBBLE = '0;
    localparam logic [CNT_W-1:0] LAST_NIBBLE  = CNT_W'(NUM_NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [NIBBLE-1:0] get_nibble(
        input logic [WIDTH-1:0] word,
        input logic [CNT_W-1:0] idx
    );
        logic [NIBBLE-1:0] n;
        case (idx)
            2'd0:    n = word[3:0];
            2'd1:    n = word[7:4];
            2'd2:    n = word[11:8];
            default: n = word[15:12];
        endcase
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] set_nibble(
        input logic [WIDTH-1:0]  word,
        input logic [CNT_W-1:0]  idx,
        input logic [NIBBLE-1:0] n
    );
        logic [WIDTH-1:0] w;
        w = word;
        case (idx)
            2'd0:    w[3:0]   = n;
            2'd1:    w[7:4]   = n;
            2'd2:    w[11:8]  = n;
            default: w[15:12] = n;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/nibble_subtractor.sv
// Combinational 4-bit subtract slice with borrow-in and borrow-out.
module nibble_subtractor
    import sub_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              bi,
    output logic [NIBBLE-1:0] d,
    output logic              bo
);

    logic [NIBBLE:0] res;

    // The extra MSB goes to 1 exactly when the unsigned result is negative.
    always_comb begin
        res = {1'b0, a} - {1'b0, b} - {{NIBBLE{1'b0}}, bi};
        d   = res[NIBBLE-1:0];
        bo  = res[NIBBLE];
    end

endmodule

// File: rtl/serial_sub16_ctrl.sv
// Serial 16-bit subtractor: one shared nibble slice walks the operands LSB
// first over four RUN cycles, then publishes the result for one DONE cycle.
module serial_sub16_ctrl
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              bin_q, bin_d;
    logic              borrow_q, borrow_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [NIBBLE-1:0] slice_a;
    logic [NIBBLE-1:0] slice_b;
    logic              slice_bi;
    logic [NIBBLE-1:0] slice_d;
    logic              slice_bo;
    logic [WIDTH-1:0]  work_next;

    always_comb begin
        slice_a  = get_nibble(a_q, cnt_q);
        slice_b  = get_nibble(b_q, cnt_q);
        slice_bi = (cnt_q == FIRST_NIBBLE) ? bin_q : borrow_q;
    end

    nibble_subtractor u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .bi (slice_bi),
        .d  (slice_d),
        .bo (slice_bo)
    );

    always_comb begin
        work_next = set_nibble(work_q, cnt_q, slice_d);

        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        work_d   = work_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    bin_d    = bin;
                    borrow_d = 1'b0;
                    cnt_d    = FIRST_NIBBLE;
                    state_d  = RUN;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                work_d   = work_next;
                borrow_d = slice_bo;
                cnt_d    = cnt_q + 2'd1;
                // Visible outputs change only here so partial sums never leak.
                if (cnt_q == LAST_NIBBLE) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = work_next;
                    bout_d  = slice_bo;
                    zero_d  = (work_next == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            work_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub16_ctrl.sv
// Bench for serial_sub16_ctrl: vector table and random sweep feed a result
// scoreboard; hand sequences cover held start, reset abort and back-to-back.
module tb_serial_sub16_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        zero;

    serial_sub16_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } exp_t;

    vec_t        vecs[9];
    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] prev_diff = 16'h0000;
    int unsigned cycle_ctr = 0;
    int unsigned done_last = 0;
    int unsigned done_prev = 0;

    always @(posedge clk) cycle_ctr <= cycle_ctr + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b} - {16'h0000, bi};
        e.diff = r[15:0];
        e.bout = r[16];
        e.zero = (r[15:0] == 16'h0000);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest accepted op.
    always begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            n_checks++;
            done_prev = done_last;
            done_last = cycle_ctr;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: diff=%h bout=%b zero=%b with empty scoreboard",
                         diff, bout, zero);
            end else begin
                mon_e = sb.pop_front();
                if ({diff, bout, zero} !== {mon_e.diff, mon_e.bout, mon_e.zero}) begin
                    n_errors++;
                    $display("FAIL result: diff=%h bout=%b zero=%b expected diff=%h bout=%b zero=%b",
                             diff, bout, zero, mon_e.diff, mon_e.bout, mon_e.zero);
                end
                prev_diff = mon_e.diff;
            end
        end
    end

    // Starts from an IDLE cycle and returns in the IDLE cycle after DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input exp_t e, input bit noisy);
        int cyc;
        a_in  = a;
        b_in  = b;
        bin   = bi;
        start = 1'b1;
        sb.push_back(e);
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc < 5) chk("busy_run", 32'(busy), 32'd1);
            if (cyc == 3) chk("diff_hold", 32'(diff), 32'(prev_diff));
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                a_in  = 16'($urandom);
                b_in  = 16'($urandom);
                bin   = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end while (done !== 1'b1 && cyc < 12);
        chk("latency", 32'(cyc), 32'd5);
        start = 1'b0;
        tick();
        chk("done_width", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [15:0] ha[13];
    logic [15:0] hb[13];
    logic        hbi[13];
    exp_t        e;

    initial begin
        vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};
        vecs[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};

        // Reset with start held: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 16'hABCD;
        b_in  = 16'h1234;
        bin   = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Table vectors, run back to back.
        for (int i = 0; i < 9; i++) begin
            e.diff = vecs[i].diff;
            e.bout = vecs[i].bout;
            e.zero = vecs[i].zero;
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, e, (i % 2) == 1);
        end
        chk("b2b_gap", done_last - done_prev, 32'd6);

        // Start held high for ten cycles while operands change every cycle.
        for (int c = 0; c < 13; c++) begin
            ha[c]  = 16'($urandom);
            hb[c]  = 16'($urandom);
            hbi[c] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 13; c++) begin
            chk("held_done", 32'(done), (c == 5 || c == 11) ? 32'd1 : 32'd0);
            chk("held_busy", 32'(busy), (c == 0 || c == 6 || c == 12) ? 32'd0 : 32'd1);
            a_in  = ha[c];
            b_in  = hb[c];
            bin   = hbi[c];
            start = (c < 10);
            if (c == 0 || c == 6) sb.push_back(model(ha[c], hb[c], hbi[c]));
            tick();
        end
        start = 1'b0;

        // Reset asserted in cycle 3 of an operation aborts it.
        a_in  = 16'h5555;
        b_in  = 16'h1111;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_diff = 16'h0000;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // Random sweep against the word-level model, with noisy inputs in flight.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rbi;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            if (i % 50 == 0) rb = ra;
            run_op(ra, rb, rbi, model(ra, rb, rbi), 1'b1);
        end

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_sub16_ctrl.md
SERIAL_SUB16_CTRL -- requirements
Module: serial_sub16_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: start  input  1  request to begin one 16-bit subtraction.
REQ-004 SHALL have: a_in  input  16  minuend, sampled on accepted start.
REQ-005 SHALL have: b_in  input  16  subtrahend, sampled on accepted start.
REQ-006 SHALL have: bin  input  1  borrow-in, sampled on accepted start.
REQ-007 SHALL have: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have: done  output  1  single-cycle pulse marking a valid new result.
REQ-009 SHALL have: diff  output  16  result a_in - b_in - bin, modulo 2^16.
REQ-010 SHALL have: bout  output  1  borrow-out: 1 when a_in < b_in + bin (unsigned).
REQ-011 SHALL have: zero  output  1  1 when diff == 16'h0000.

Function
REQ-012 SHALL time-share one 4-bit subtract slice over four nibbles, LSB nibble first.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at a clock edge -> latch a_in, b_in, bin; clear nibble counter to 0; go to RUN.
REQ-015 IDLE: start=0 -> stay in IDLE.
REQ-016 RUN: each cycle, process nibble[cnt]; slice borrow-in = latched bin for cnt=0, else the registered borrow from nibble cnt-1.
REQ-017 RUN: each cycle, store the slice difference in a working register nibble [4*cnt+3:4*cnt] and register the slice borrow-out; increment cnt.
REQ-018 RUN: on the edge that processes cnt=3, go to DONE; cnt SHALL wrap to 0.
REQ-019 DONE: done=1 for exactly one cycle; then IDLE unconditionally.
REQ-020 Latency: start high in cycle 0 -> RUN in cycles 1-4 -> done=1 in cycle 5.
REQ-021 diff, bout and zero SHALL update only on the edge entering DONE, and SHALL hold until the next DONE entry; partial results are never visible.
REQ-022 start while busy=1 (RUN or DONE) SHALL be ignored, with no effect on operands or state.
REQ-023 Back-to-back: start accepted in IDLE in the cycle immediately after DONE -> next done=1 six cycles after the previous done.
REQ-024 a_in, b_in and bin changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 Slice arithmetic SHALL be true unsigned subtraction: {bo,d} = {1'b0,a} - {1'b0,b} - bi, where bo is the slice borrow-out and d is the 4-bit slice difference.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, cnt=0, busy=0, done=0, diff=16'h0000, bout=0, zero=1; operand and borrow registers cleared.
REQ-027 rst asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package sub_pkg SHALL hold WIDTH=16, NIBBLE=4, NUM_NIBBLES=4, and the FSM state enum.
REQ-030 The slice SHALL be a separate combinational sub-module, nibble_subtractor (a, b, bi -> d, bo), instantiated once.
REQ-031 The counter SHALL be 2 bits; no other arithmetic on operand data outside nibble_subtractor.

Verification
REQ-032 a_in=16'h1234, b_in=16'h0235, bin=0 -> done in cycle 5; diff=16'h0FFF, bout=0, zero=0.
REQ-033 a_in=16'h0000, b_in=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, zero=0; a_in=16'h0000, b_in=16'h0000, bin=1 -> diff=16'hFFFF, bout=1.
REQ-034 a_in=16'h8000, b_in=16'h8000, bin=0 -> diff=16'h0000, bout=0, zero=1.
REQ-035 Start held high for 10 cycles with changing operands -> results correspond only to operands captured in IDLE; done pulses in cycles 5 and 11; busy never drops during RUN.
REQ-036 rst pulsed in cycle 3 of an operation -> IDLE next cycle, outputs at reset values, no done pulse.
REQ-037 Random sweep of 1000 operations against a 17-bit reference model -> {bout,diff} matches on every done pulse.
